// File: rtl/score_bcd_accumulator.sv
// -----------------------------------------------------------------------------
// score_bcd_accumulator
//
// Running game score for the Breakout score display. The score is held as
// NUM_DIGITS packed BCD digits. Point awards arrive on a valid/ready handshake
// and are added serially, one digit per clock. Committed digits and per-digit
// leading-zero blank flags feed the seven-segment digit drivers directly.
//
// Optional feature (macro SCORE_CLEAR_EN): adds the synchronous 'clear' input.
// It starts a new game by zeroing the score and aborting any award in flight.
//
// Ports:
//   clock       in   system clock, all state on rising edge
//   reset_L     in   asynchronous active-low reset
//   clear       in   (SCORE_CLEAR_EN only) synchronous new-game clear
//   add_valid   in   award request valid
//   add_amount  in   points to add 0-9 (10-15 clamp to 9)
//   add_ready   out  idle, can accept an award
//   done        out  one-cycle pulse when a new score is committed
//   bcd         out  committed score, digit i at [4i+3:4i], digit 0 = ones
//   blank       out  blank[i]=1 means digit i is a leading zero
//   saturated   out  score reached all nines, sticky until reset
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for an award, add_ready high
// ADD    | adding one digit per clock, exactly NUM_DIGITS cycles
// -----------------------------------------------------------------------------
module score_bcd_accumulator #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset_L,
`ifdef SCORE_CLEAR_EN
    input  logic                    clear,
`endif
    input  logic                    add_valid,
    input  logic [3:0]              add_amount,
    output logic                    add_ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    saturated
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ADD  = 1'b1;

    localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [NUM_DIGITS-1:0]   BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_DIGITS-1);

    logic [0:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_work;
    logic [3:0]              r_carry;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_sat;
    logic                    r_done;

    logic                    w_clear;
    logic [3:0]              w_clamped;
    logic [3:0]              w_digit;
    logic [4:0]              w_sum;
    logic                    w_carry_out;
    logic [3:0]              w_new_digit;
    logic [4*NUM_DIGITS-1:0] w_work_next;
    logic [4*NUM_DIGITS-1:0] w_commit;
    logic [NUM_DIGITS-1:0]   w_blank_next;
    logic                    w_last;
    logic                    w_zero_above;

`ifdef SCORE_CLEAR_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    assign w_clamped = (add_amount > 4'd9) ? 4'd9 : add_amount;
    assign w_last    = (r_idx == LAST_IDX);

    // Select the digit currently being updated.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_work[4*i +: 4];
            end
        end
    end

    // Digit plus carry is at most 9+9=18. For 10..18, sum-10 equals
    // sum+6 modulo 16, which keeps the arithmetic in 4 bits.
    assign w_sum       = {1'b0, w_digit} + {1'b0, r_carry};
    assign w_carry_out = (w_sum > 5'd9);
    assign w_new_digit = w_carry_out ? (w_sum[3:0] + 4'd6) : w_sum[3:0];

    always_comb begin
        w_work_next = r_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_work_next[4*i +: 4] = w_new_digit;
            end
        end
    end

    // Overflow out of the top digit pins the score at all nines.
    assign w_commit = w_carry_out ? ALL_NINES : w_work_next;

    // A digit above the ones place is blank when it and everything above it is zero.
    always_comb begin
        w_blank_next = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS-1; i >= 1; i--) begin
            w_zero_above    = w_zero_above & (w_commit[4*i +: 4] == 4'd0);
            w_blank_next[i] = w_zero_above;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_carry <= 4'd0;
            r_idx   <= '0;
            r_bcd   <= '0;
            r_blank <= BLANK_RST;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_clear) begin
            // New game: discards any award in flight or arriving this edge.
            r_state <= S_IDLE;
            r_carry <= 4'd0;
            r_idx   <= '0;
            r_bcd   <= '0;
            r_blank <= BLANK_RST;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (add_valid) begin
                    r_work  <= r_bcd;
                    r_carry <= w_clamped;
                    r_idx   <= '0;
                    r_state <= S_ADD;
                end
            end else begin
                r_work  <= w_work_next;
                r_carry <= {3'b000, w_carry_out};
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_bcd   <= w_commit;
                    r_blank <= w_blank_next;
                    if (w_carry_out) begin
                        r_sat <= 1'b1;
                    end
                end
            end
        end
    end

    assign add_ready = (r_state == S_IDLE);
    assign done      = r_done;
    assign bcd       = r_bcd;
    assign blank     = r_blank;
    assign saturated = r_sat;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
module tb_score_bcd_accumulator;

    localparam int N = 4;

    logic          clock;
    logic          reset_L;
    logic          clear;
    logic          add_valid;
    logic [3:0]    add_amount;
    logic          add_ready;
    logic          done;
    logic [4*N-1:0] bcd;
    logic [N-1:0]  blank;
    logic          saturated;

    int n_cmp = 0;
    int n_err = 0;

    score_bcd_accumulator #(.NUM_DIGITS(N)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
`ifdef SCORE_CLEAR_EN
        .clear      (clear),
`endif
        .add_valid  (add_valid),
        .add_amount (add_amount),
        .add_ready  (add_ready),
        .done       (done),
        .bcd        (bcd),
        .blank      (blank),
        .saturated  (saturated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bcd"},   32'(bcd),       32'h0000);
        check({tag, "_blank"}, 32'(blank),     32'b1110);
        check({tag, "_ready"}, 32'(add_ready), 32'd1);
        check({tag, "_sat"},   32'(saturated), 32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    // One award: accept on the next rising edge, then follow the ADD phase
    // edge by edge. With chk set, ready/done timing is verified.
    task automatic award(input logic [3:0] amt, input bit hold, input bit chk);
        @(negedge clock);
        add_valid  = 1'b1;
        add_amount = amt;
        @(posedge clock); #1;
        if (!hold) add_valid = 1'b0;
        if (chk) check("ready_low_after_accept", 32'(add_ready), 32'd0);
        for (int j = 1; j < N; j++) begin
            @(posedge clock); #1;
            if (chk) begin
                check("ready_low_in_add", 32'(add_ready), 32'd0);
                check("done_early",       32'(done),      32'd0);
            end
        end
        @(posedge clock); #1;
        add_valid = 1'b0;
        if (chk) begin
            check("done_at_commit",  32'(done),      32'd1);
            check("ready_at_commit", 32'(add_ready), 32'd1);
        end
        @(posedge clock); #1;
        if (chk) check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_L = 1'b0;
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L    = 1'b0;
        clear      = 1'b0;
        add_valid  = 1'b0;
        add_amount = 4'd0;
        #12;
        check_reset_state("reset");
        @(negedge clock);
        reset_L = 1'b1;

        award(4'd7, 1'b0, 1'b1);
        check("add7_bcd",   32'(bcd),   32'h0007);
        check("add7_blank", 32'(blank), 32'b1110);
        award(4'd5, 1'b0, 1'b1);
        check("add5_bcd",   32'(bcd),   32'h0012);
        check("add5_blank", 32'(blank), 32'b1100);
        award(4'd0, 1'b0, 1'b1);
        check("add0_bcd",   32'(bcd),   32'h0012);

        // 999 = 111 awards of 9
        do_reset();
        for (int i = 0; i < 111; i++) award(4'd9, 1'b0, 1'b0);
        check("pre999_bcd",   32'(bcd),   32'h0999);
        check("pre999_blank", 32'(blank), 32'b1000);
        award(4'd1, 1'b0, 1'b1);
        check("ripple_bcd",   32'(bcd),   32'h1000);
        check("ripple_blank", 32'(blank), 32'b0000);

        // 9995 = 1110 awards of 9 plus 5
        do_reset();
        for (int i = 0; i < 1110; i++) award(4'd9, 1'b0, 1'b0);
        award(4'd5, 1'b0, 1'b0);
        check("pre9995_bcd", 32'(bcd),       32'h9995);
        check("pre9995_sat", 32'(saturated), 32'd0);
        award(4'd9, 1'b0, 1'b1);
        check("sat_bcd",   32'(bcd),       32'h9999);
        check("sat_flag",  32'(saturated), 32'd1);
        check("sat_blank", 32'(blank),     32'b0000);
        award(4'd3, 1'b0, 1'b1);
        check("sat_hold_bcd",  32'(bcd),       32'h9999);
        check("sat_hold_flag", 32'(saturated), 32'd1);

        // Clamp, with valid held high through ADD
        do_reset();
        award(4'hF, 1'b1, 1'b1);
        check("clamp_bcd", 32'(bcd), 32'h0009);
        @(posedge clock); #1;
        check("clamp_no_second_ready", 32'(add_ready), 32'd1);
        check("clamp_no_second_bcd",   32'(bcd),       32'h0009);

        // Reset two cycles into ADD
        @(negedge clock);
        add_valid  = 1'b1;
        add_amount = 4'd3;
        @(posedge clock); #1;
        add_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_L = 1'b0;
        #1;
        check_reset_state("midadd_reset");
        @(negedge clock);
        reset_L = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int j = 0; j < N + 2; j++) begin
                @(posedge clock); #1;
                if (done) seen_done++;
            end
            check("midadd_no_done", 32'(seen_done), 32'd0);
        end
        check("midadd_bcd", 32'(bcd), 32'h0000);

`ifdef SCORE_CLEAR_EN
        award(4'd6, 1'b0, 1'b0);
        check("preclear_bcd", 32'(bcd), 32'h0006);
        @(negedge clock);
        add_valid  = 1'b1;
        add_amount = 4'd4;
        clear      = 1'b1;
        @(posedge clock); #1;
        add_valid = 1'b0;
        clear     = 1'b0;
        check_reset_state("clear_vs_accept");
        @(posedge clock); #1;
        check("clear_ready_next", 32'(add_ready), 32'd1);
        check("clear_bcd_next",   32'(bcd),       32'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
